// File: rtl/icache_sa.sv
// Set-associative instruction cache with blocking single-line refill.
// Optional hit/miss event counters are built when ICACHE_SA_PERF_EN is defined.
module icache_sa #(
    parameter int unsigned WAYS            = 2,
    parameter int unsigned SETS            = 64,
    parameter int unsigned WORDS_PER_BLOCK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_instr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        flush
`ifdef ICACHE_SA_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;

    state_t             state_q;
    logic [31:0]        addr_q;
    logic               hit_q;
    logic [WAY_W-1:0]   victim_q;
    logic               had_inv_q;
    logic [OFF_W-1:0]   beat_q;
    logic               flush_pend_q;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAY_W-1:0]   rr_q    [SETS];

    // Tag and data storage carry no reset; validity lives in valid_q.
    logic [TAG_W-1:0]   tag_mem  [WAYS][SETS];
    logic [31:0]        data_mem [WAYS][SETS][WORDS_PER_BLOCK];

    logic [TAG_W-1:0]   req_tag, cur_tag;
    logic [IDX_W-1:0]   req_idx, cur_idx;
    logic [OFF_W-1:0]   req_word, cur_word;
    logic               lk_hit;
    logic [31:0]        lk_word;
    logic               inv_any;
    logic [WAY_W-1:0]   inv_way;
    logic               fill_we;
    logic               last_beat;
    logic [31:0]        fill_word;

    assign req_tag  = req_addr[31 -: TAG_W];
    assign req_idx  = req_addr[OFF_W+2 +: IDX_W];
    assign req_word = req_addr[2 +: OFF_W];
    assign cur_tag  = addr_q[31 -: TAG_W];
    assign cur_idx  = addr_q[OFF_W+2 +: IDX_W];
    assign cur_word = addr_q[2 +: OFF_W];

    assign req_ready = (state_q == IDLE) && !flush && !flush_pend_q;
    assign fill_we   = (state_q == REFILL) && mem_resp_valid;
    assign last_beat = (beat_q == OFF_W'(WORDS_PER_BLOCK - 1));
    // Requested word of the line being filled; the final beat bypasses the array.
    assign fill_word = (cur_word == beat_q) ? mem_resp_data
                                            : data_mem[victim_q][cur_idx][cur_word];

    // Tag compare across all ways of the incoming request's set.
    always_comb begin
        lk_hit  = 1'b0;
        lk_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
                lk_hit  = 1'b1;
                lk_word = data_mem[w][req_idx][req_word];
            end
        end
    end

    // Lowest-numbered invalid way in the current set, if any.
    always_comb begin
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[cur_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    // Line storage write port, fed by refill beats.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[victim_q][cur_idx][beat_q] <= mem_resp_data;
            if (last_beat) begin
                tag_mem[victim_q][cur_idx] <= cur_tag;
            end
        end
    end

    // Control FSM with registered response/refill outputs and line state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            hit_q         <= 1'b0;
            victim_q      <= '0;
            had_inv_q     <= 1'b0;
            beat_q        <= '0;
            flush_pend_q  <= 1'b0;
            resp_valid    <= 1'b0;
            resp_instr    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
`ifdef ICACHE_SA_PERF_EN
            hit_count     <= '0;
            miss_count    <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            if (flush && (state_q != IDLE)) begin
                flush_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (flush || flush_pend_q) begin
                        flush_pend_q <= 1'b0;
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                            rr_q[s]    <= '0;
                        end
                    end else if (req_valid) begin
                        addr_q  <= req_addr;
                        hit_q   <= lk_hit;
                        state_q <= LOOKUP;
                        if (lk_hit) begin
                            resp_valid <= 1'b1;
                            resp_instr <= lk_word;
                        end
                    end
                end
                LOOKUP: begin
                    if (hit_q) begin
                        state_q <= IDLE;
`ifdef ICACHE_SA_PERF_EN
                        if (hit_count != '1) hit_count <= hit_count + 32'd1;
`endif
                    end else begin
                        victim_q      <= inv_any ? inv_way : rr_q[cur_idx];
                        had_inv_q     <= inv_any;
                        beat_q        <= '0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {addr_q[31:OFF_W+2], (OFF_W+2)'(0)};
                        state_q       <= MISS_REQ;
`ifdef ICACHE_SA_PERF_EN
                        if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_q       <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_resp_valid) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (last_beat) begin
                            valid_q[cur_idx][victim_q] <= 1'b1;
                            if (!had_inv_q) begin
                                rr_q[cur_idx] <= (rr_q[cur_idx] == WAY_W'(WAYS - 1)) ? '0
                                                 : rr_q[cur_idx] + WAY_W'(1);
                            end
                            resp_valid <= 1'b1;
                            resp_instr <= fill_word;
                            beat_q     <= '0;
                            state_q    <= RESP;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/icache_sa.md
ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 SHALL provide parameter WAYS, 2, associativity (power of two, 1..8).
REQ-002 SHALL provide parameter SETS, 64, sets per way (power of two, 2..1024).
REQ-003 SHALL provide parameter WORDS_PER_BLOCK, 4, 32-bit words per line (power of two, 2..16).
REQ-004 SHALL provide port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port req_valid / req_ready  input / output  1 / 1  fetch request handshake.
REQ-007 SHALL provide port req_addr  input  32  byte address of fetch; bits [1:0] ignored.
REQ-008 SHALL provide port resp_valid  output  1  one-cycle pulse, resp_instr valid.
REQ-009 SHALL provide port resp_instr  output  32  fetched instruction word.
REQ-010 SHALL provide port mem_req_valid / mem_req_ready  output / input  1 / 1  refill request handshake.
REQ-011 SHALL provide port mem_req_addr  output  32  block-aligned refill address.
REQ-012 SHALL provide port mem_resp_valid / mem_resp_data  input / input  1 / 32  refill beat, word order ascending.
REQ-013 SHALL provide port flush  input  1  invalidate all lines.
REQ-014 SHALL, with ICACHE_SA_PERF_EN defined, provide ports hit_count and miss_count, output, 32 each, saturating event counters.

Function
REQ-015 SHALL decode address as tag = [31:log2(SETS)+log2(WPB)+2], index = next log2(SETS) bits, word = [log2(WPB)+1:2].
REQ-016 SHALL implement states IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
REQ-017 SHALL assert req_ready only in IDLE with flush low; request accepted on req_valid && req_ready, address registered, go to LOOKUP.
REQ-018 SHALL in LOOKUP compare the tag against all WAYS ways of the set; on hit, drive resp_valid=1 and resp_instr=stored word the same cycle and return to IDLE (hit latency: response 1 cycle after acceptance).
REQ-019 SHALL on miss in LOOKUP select victim: lowest-numbered invalid way, else the per-set round-robin pointer; go to MISS_REQ.
REQ-020 SHALL in MISS_REQ hold mem_req_valid=1 with mem_req_addr={addr[31:offset],0} until mem_req_ready, then go to REFILL; mem_req_valid SHALL be 0 in all other states.
REQ-021 SHALL in REFILL write each mem_resp_valid beat into the victim way at beat counter 0..WPB-1; beats with mem_resp_valid low SHALL not advance the counter.
REQ-022 SHALL on final beat write tag, set valid, advance that set's round-robin pointer modulo WAYS (only when no invalid way existed), and go to RESP.
REQ-023 SHALL in RESP drive resp_valid=1 with the requested word from the filled line, then return to IDLE.
REQ-024 SHALL, when flush is high in IDLE, clear all valid bits and round-robin pointers in that cycle; flush high in other states SHALL be latched and applied on the next IDLE cycle, invalidating any line just filled.
REQ-025 SHALL ignore mem_resp_valid outside REFILL.
REQ-026 SHALL keep resp_instr stable between resp_valid pulses.

Reset
REQ-027 SHALL on reset assert: state IDLE, all valid bits 0, round-robin pointers 0, beat counter 0, pending flush 0, resp_valid 0, resp_instr 0, mem_req_valid 0, mem_req_addr 0, counters 0.
REQ-028 SHALL abandon any in-flight refill on reset mid-operation; the partially filled line remains invalid.
REQ-029 SHALL not require data or tag arrays to be reset.

Configuration
REQ-030 SHALL, with ICACHE_SA_PERF_EN defined, increment hit_count on each LOOKUP hit and miss_count on each LOOKUP miss, saturating at 0xFFFFFFFF.
REQ-031 SHALL, without ICACHE_SA_PERF_EN, omit the counter ports and logic entirely; other behaviour identical.

Verification
REQ-032 SHALL cover cold miss: WAYS=2, WPB=4, fetch 0x0000_1008 -> mem_req_addr=0x0000_1000, 4 beats D0..D3, resp_instr=D2; refetch 0x1008 -> hit, resp 1 cycle after accept.
REQ-033 SHALL cover conflict: fill 0x0000_1000 and 0x0001_1000 (same set) -> both hit; third tag 0x0002_1000 evicts way 0; 0x0001_1000 still hits.
REQ-034 SHALL cover stalls: mem_req_ready low 5 cycles and mem_resp_valid gapped -> correct line, req_ready low throughout.
REQ-035 SHALL cover flush during REFILL -> refill completes, RESP delivered, next fetch of same address misses.
REQ-036 SHALL cover reset asserted after 2 of 4 beats -> all outputs at reset values; next fetch of that address misses.
REQ-037 SHALL cover PERF_EN: 3 misses + 5 hits -> miss_count=3, hit_count=5.
